debounce_tick_bank: RTL and testbench
=====================================

# debounce_tick_bank

Parametrised successor to the team's fixed slow-clock debounce divider. Generates an exact-period single-cycle enable tick from `in_clk` and uses it to debounce a bank of `N_CH` asynchronous button/switch inputs. Provides clean levels plus rise/fall pulses for the game FSM, and a 50 %-duty `slow_clk` for the display and LED logic that currently consume a divided clock. All outputs are in the `in_clk` domain; no derived clock drives any flop inside the block.

## Interface
Parameters:
- `CLK_DIV`, default 12500000: tick period in `in_clk` cycles; must be ≥ 2.
- `N_CH`, default 4: number of debounced channels; must be ≥ 1.
- `STABLE_TICKS`, default 4: consecutive ticks a new input value must persist before it is accepted; must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `in_clk`  in  1  system clock.
- `in_rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  tick enable; low freezes the divider.
- `btn_in`  in  N_CH  raw asynchronous inputs.
- `btn_level`  out  N_CH  debounced level.
- `btn_rise`  out  N_CH  one-cycle pulse on a debounced 0→1 transition.
- `btn_fall`  out  N_CH  one-cycle pulse on a debounced 1→0 transition.
- `tick_out`  out  1  one-cycle strobe, period `CLK_DIV`.
- `slow_clk`  out  1  toggles on every tick; period 2·`CLK_DIV`.

## Operation
- Reset values: divider count 0, `tick_out` 0, `slow_clk` 0, synchronizers 0, `btn_level` 0, `btn_rise` 0, `btn_fall` 0, stability counters 0.
- Divider behaviour when `en` is high:
  - Count increments each cycle.
  - At `CLK_DIV-1` the count wraps to 0 and `tick_out` is registered high for the next cycle.
  - The period is exact, with no off-by-one cycle.
- When `en` is low, the count holds and `tick_out` is 0. The channel logic still runs but sees no ticks.
- Each channel has a 2-FF synchronizer on `btn_in[i]`, always clocked.
- On each cycle where `tick_out`=1, each channel compares its synchronized input `s` with `btn_level[i]`:
  - If `s == btn_level[i]`, the stability counter clears.
  - Otherwise the counter increments.
  - When the counter reaches `STABLE_TICKS-1` while still mismatched, `btn_level[i]` takes `s` and the counter clears.
- A single mismatch-free tick restarts qualification, so bounces shorter than `STABLE_TICKS` ticks are rejected.
- `btn_rise[i]` / `btn_fall[i]` assert in the same cycle that `btn_level[i]` changes, for exactly one cycle.
- Channels are fully independent. Several channels may update on the same tick.
- Counter width is `$clog2(CLK_DIV)` for the divider and `$clog2(STABLE_TICKS+1)` per channel. Neither counter may overflow.

## Timing
- `tick_out` first goes high in the cycle after the `CLK_DIV`-th enabled rising edge following reset release. Thereafter it is high 1 cycle in every `CLK_DIV` enabled cycles.
- `slow_clk` toggles in the same cycle `tick_out` is high.
- Channel latency from a clean `btn_in` edge:
  - 2 cycles of synchronization.
  - Then acceptance on the `STABLE_TICKS`-th tick sampling the new value.
  - `btn_level` and the pulse appear 1 cycle after that tick.
- Worst-case latency is `2 + STABLE_TICKS·CLK_DIV + 1` cycles.
- Reset mid-operation clears all state immediately, asynchronously. No pulse is emitted on reset entry or exit.
- If `en` is deasserted mid-period, the count resumes from its held value, so no short period is produced.

## Structure
- Shared package `rng_game_pkg`: default `CLK_DIV` constant (12500000 for 25 MHz/50 MHz boards) and a `DEB_STABLE_DEFAULT` constant.
- Sub-module `tick_gen` contains the divider, `tick_out` and `slow_clk`, and is reusable standalone.
- Per-channel logic is a generate loop in the top module. It is not a separate module.
- Elaboration-time checks on parameter legality.

## Test plan
Run with `CLK_DIV`=4, `STABLE_TICKS`=3, `N_CH`=2 unless noted.
- Reset, then `en`=1 for 20 cycles → `tick_out` high in cycles 4, 8, 12, 16, 20 after release; `slow_clk` toggles at each; all button outputs 0.
- Hold `btn_in[0]`=1 steady → `btn_level[0]`=1 with a single-cycle `btn_rise[0]` on the cycle after the 3rd tick sampling 1; `btn_level[1]` stays 0.
- Toggle `btn_in[0]` 1 → 0 → 1 with each value held for 2 ticks → `btn_level[0]` never changes; no pulses.
- Both channels rise together → simultaneous `btn_rise`=2'b11 for one cycle; later release → `btn_fall`=2'b11.
- `en` low for 7 cycles mid-period → no ticks; the period resumes with the remaining count; total tick spacing is 4 enabled cycles.
- Assert `in_rst_n`=0 while a channel has 2/3 qualification → all outputs 0 immediately. After release, full re-qualification is needed; no spurious `btn_fall`/`btn_rise`.

Source files
------------

// File: rtl/rng_game_pkg.sv
// Shared constants for the game board blocks.
//   CLK_DIV_DEFAULT    : slow-tick divisor for 25 MHz / 50 MHz boards
//   DEB_STABLE_DEFAULT : ticks a new button value must persist before acceptance
//   DEB_N_CH_DEFAULT   : default number of debounced channels
//   cnt_width()        : width of a counter that must hold values 0..n-1 (never below 1)
package rng_game_pkg;

    localparam int CLK_DIV_DEFAULT    = 12_500_000;
    localparam int DEB_STABLE_DEFAULT = 4;
    localparam int DEB_N_CH_DEFAULT   = 4;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_tick_bank_if.sv
// Bundle of the debounce bank's functional signals.
//   master : drives en / btn_in, observes the debounced outputs and the tick
//   slave  : the debounce bank itself
// Signals: en (divider enable), btn_in (raw inputs), btn_level / btn_rise /
// btn_fall (debounced level and edge pulses), tick_out (enable strobe),
// slow_clk (50 % duty square wave, in the in_clk domain).
interface debounce_tick_bank_if #(
    parameter int N_CH = 4
) ();

    logic            en;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;
    logic            tick_out;
    logic            slow_clk;

    modport master (
        output en,
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  tick_out,
        input  slow_clk
    );

    modport slave (
        input  en,
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output tick_out,
        output slow_clk
    );

endinterface

// File: rtl/debounce_tick_bank_tick_gen.sv
// tick_gen: exact-period enable-tick generator, usable on its own.
//   in_clk   : system clock
//   in_rst_n : asynchronous active-low reset
//   en       : count enable; low holds the count and suppresses the tick
//   tick_out : one-cycle strobe, once every CLK_DIV enabled cycles
//   slow_clk : toggles together with each tick (period 2*CLK_DIV)
module tick_gen
    import rng_game_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic en,
    output logic tick_out,
    output logic slow_clk
);

    localparam int             CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("tick_gen: CLK_DIV must be >= 2");
        end
    endgenerate

    // Wrapping at CLK_DIV-1 while registering the tick keeps the period
    // exactly CLK_DIV enabled cycles; a held count resumes where it stopped.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            count    <= '0;
            tick_out <= 1'b0;
            slow_clk <= 1'b0;
        end else if (en) begin
            if (count == LAST) begin
                count    <= '0;
                tick_out <= 1'b1;
                slow_clk <= ~slow_clk;
            end else begin
                count    <= count + 1'b1;
                tick_out <= 1'b0;
            end
        end else begin
            tick_out <= 1'b0;
        end
    end

endmodule

// File: rtl/debounce_tick_bank.sv
// debounce_tick_bank: tick-paced debouncer for a bank of asynchronous inputs.
//   in_clk   : system clock (the only clock of every flop in here)
//   in_rst_n : asynchronous active-low reset
//   bus      : slave side of debounce_tick_bank_if
//              en / btn_in in; btn_level, btn_rise, btn_fall, tick_out,
//              slow_clk out
// Each channel: 2-FF synchronizer, then on every tick a consecutive-mismatch
// counter; the new value is accepted on the STABLE_TICKS-th mismatched tick.
module debounce_tick_bank
    import rng_game_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEFAULT,
    parameter int N_CH         = DEB_N_CH_DEFAULT,
    parameter int STABLE_TICKS = DEB_STABLE_DEFAULT
) (
    input logic                 in_clk,
    input logic                 in_rst_n,
    debounce_tick_bank_if.slave bus
);

    localparam int             STAB_W    = cnt_width(STABLE_TICKS + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

    generate
        if (N_CH < 1) begin : g_bad_n_ch
            $error("debounce_tick_bank: N_CH must be >= 1");
        end
        if (STABLE_TICKS < 1) begin : g_bad_stable
            $error("debounce_tick_bank: STABLE_TICKS must be >= 1");
        end
    endgenerate

    logic tick;
    logic slow;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .en       (bus.en),
        .tick_out (tick),
        .slow_clk (slow)
    );

    assign bus.tick_out = tick;
    assign bus.slow_clk = slow;

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              sync1;
        logic              sync2;
        logic              lvl;
        logic              rise_q;
        logic              fall_q;
        logic [STAB_W-1:0] stab;

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                lvl    <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                stab   <= '0;
            end else begin
                sync1  <= bus.btn_in[i];
                sync2  <= sync1;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (tick) begin
                    if (sync2 == lvl) begin
                        stab <= '0;
                    end else if (stab == STAB_LAST) begin
                        // Mismatch has now held for STABLE_TICKS ticks in a row.
                        lvl    <= sync2;
                        stab   <= '0;
                        rise_q <= sync2;
                        fall_q <= ~sync2;
                    end else begin
                        stab <= stab + 1'b1;
                    end
                end
            end
        end

        assign level[i] = lvl;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

    assign bus.btn_level = level;
    assign bus.btn_rise  = rise;
    assign bus.btn_fall  = fall;

endmodule

// File: tb/tb_debounce_tick_bank.sv
module tb_debounce_tick_bank;

    localparam int CD = 4;
    localparam int ST = 3;
    localparam int NC = 2;

    logic clk;
    logic rst_n;

    debounce_tick_bank_if #(.N_CH(NC)) bus ();

    debounce_tick_bank #(
        .CLK_DIV      (CD),
        .N_CH         (NC),
        .STABLE_TICKS (ST)
    ) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: enabled-cycle arithmetic for the divider, a two-deep
    // delay queue for the synchronizer, and a run length of mismatched ticks.
    int         en_cycles;
    logic       m_tick;
    logic       m_slow;
    logic [1:0] m_lvl;
    logic [1:0] m_rise;
    logic [1:0] m_fall;
    int         run [NC];
    logic [1:0] sq[$];

    // Observation statistics
    int en_idx;
    int last_tick_en;
    int sp_min;
    int sp_max;
    int n_spacing;
    int n_tick;
    int n_rise0;
    int n_fall0;
    int n_rise_both;
    int n_fall_both;
    int n_fall_any;

    function automatic void model_reset();
        en_cycles = 0;
        m_tick    = 1'b0;
        m_slow    = 1'b0;
        m_lvl     = 2'b00;
        m_rise    = 2'b00;
        m_fall    = 2'b00;
        for (int c = 0; c < NC; c++) run[c] = 0;
        sq = {2'b00, 2'b00};
    endfunction

    function automatic void model_step(input logic e, input logic [1:0] b);
        logic [1:0] s;
        s = sq.pop_front();
        sq.push_back(b);
        m_rise = 2'b00;
        m_fall = 2'b00;
        if (m_tick) begin
            for (int c = 0; c < NC; c++) begin
                if (s[c] == m_lvl[c]) begin
                    run[c] = 0;
                end else begin
                    run[c] = run[c] + 1;
                    if (run[c] == ST) begin
                        run[c]   = 0;
                        m_lvl[c] = s[c];
                        if (s[c]) m_rise[c] = 1'b1;
                        else      m_fall[c] = 1'b1;
                    end
                end
            end
        end
        if (e) begin
            en_cycles = en_cycles + 1;
            m_tick = ((en_cycles % CD) == 0);
            if (m_tick) m_slow = ~m_slow;
        end else begin
            m_tick = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tick_out", 32'(bus.tick_out), 32'(m_tick));
        chk("slow_clk", 32'(bus.slow_clk), 32'(m_slow));
        chk("btn_level", 32'(bus.btn_level), 32'(m_lvl));
        chk("btn_rise", 32'(bus.btn_rise), 32'(m_rise));
        chk("btn_fall", 32'(bus.btn_fall), 32'(m_fall));
    endtask

    task automatic clear_stats();
        n_tick      = 0;
        n_rise0     = 0;
        n_fall0     = 0;
        n_rise_both = 0;
        n_fall_both = 0;
        n_fall_any  = 0;
    endtask

    task automatic step(input logic e, input logic [1:0] b);
        bus.en     = e;
        bus.btn_in = b;
        @(posedge clk);
        model_step(e, b);
        if (e) en_idx++;
        #1;
        check_all();
        if (bus.tick_out) begin
            n_tick++;
            if (last_tick_en >= 0) begin
                if (en_idx - last_tick_en < sp_min) sp_min = en_idx - last_tick_en;
                if (en_idx - last_tick_en > sp_max) sp_max = en_idx - last_tick_en;
                n_spacing++;
            end
            last_tick_en = en_idx;
        end
        if (bus.btn_rise[0]) n_rise0++;
        if (bus.btn_fall[0]) n_fall0++;
        if (bus.btn_rise == 2'b11) n_rise_both++;
        if (bus.btn_fall == 2'b11) n_fall_both++;
        if (bus.btn_fall != 2'b00) n_fall_any++;
    endtask

    initial begin
        logic       found;
        logic [1:0] rb;
        logic       re;
        int         len;

        en_idx       = 0;
        last_tick_en = -1;
        sp_min       = 1000;
        sp_max       = 0;
        n_spacing    = 0;
        clear_stats();

        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.btn_in = 2'b00;
        model_reset();
        #1;
        check_all();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Divider cadence: ticks after enabled edges 4, 8, 12, 16, 20
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'b00);
            chk("tick_pos", 32'(bus.tick_out), 32'(((i % CD) == CD - 1) ? 1 : 0));
        end
        chk("tick_count20", n_tick, 5);
        chk("idle_level", 32'(bus.btn_level), 0);

        // Channel 0 held high
        clear_stats();
        repeat (24) step(1'b1, 2'b01);
        chk("rise0_once", n_rise0, 1);
        chk("level_after_rise", 32'(bus.btn_level), 32'h1);

        // Bounces held only two ticks each are rejected
        clear_stats();
        repeat (8)  step(1'b1, 2'b00);
        repeat (8)  step(1'b1, 2'b01);
        repeat (8)  step(1'b1, 2'b00);
        repeat (16) step(1'b1, 2'b01);
        chk("bounce_no_fall", n_fall0, 0);
        chk("bounce_no_rise", n_rise0, 0);
        chk("bounce_level", 32'(bus.btn_level), 32'h1);

        // Simultaneous rise and fall on both channels
        repeat (24) step(1'b1, 2'b00);
        clear_stats();
        repeat (24) step(1'b1, 2'b11);
        chk("both_rise", n_rise_both, 1);
        repeat (24) step(1'b1, 2'b00);
        chk("both_fall", n_fall_both, 1);

        // en low mid-period: no ticks while low, spacing stays 4 enabled cycles
        last_tick_en = -1;
        sp_min       = 1000;
        sp_max       = 0;
        n_spacing    = 0;
        repeat (6) step(1'b1, 2'b00);
        clear_stats();
        repeat (7) step(1'b0, 2'b00);
        chk("no_tick_en_low", n_tick, 0);
        repeat (10) step(1'b1, 2'b00);
        chk("spacing_seen", 32'(n_spacing >= 2), 1);
        chk("spacing_min", sp_min, CD);
        chk("spacing_max", sp_max, CD);

        // Reset while channel 0 is two ticks into qualification
        repeat (24) step(1'b1, 2'b10);
        chk("pre_reset_level", 32'(bus.btn_level), 32'h2);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(1'b1, 2'b11);
            if (run[0] == 2) found = 1'b1;
        end
        chk("qual_reached", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_level", 32'(bus.btn_level), 0);
        chk("rst_rise", 32'(bus.btn_rise), 0);
        chk("rst_fall", 32'(bus.btn_fall), 0);
        chk("rst_tick", 32'(bus.tick_out), 0);
        chk("rst_slow", 32'(bus.slow_clk), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'b11);
            if (i < 12) chk("requal_hold", 32'(bus.btn_level), 0);
        end
        chk("requal_level", 32'(bus.btn_level), 32'h3);
        chk("requal_rise", n_rise_both, 1);
        chk("requal_no_fall", n_fall_any, 0);

        // Randomized segments against the reference model
        for (int seg = 0; seg < 60; seg++) begin
            rb  = 2'($urandom_range(0, 3));
            re  = ($urandom_range(0, 7) != 0);
            len = $urandom_range(1, 16);
            repeat (len) step(re, rb);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
